// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding,
// XLEN, default reset PC and the fetch-queue entry layout.
package fetch_unit_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc,instr} entries between imem responses and decode.
// Clear has priority over push; push and pop may coincide on a full queue.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int   DEPTH = 2,
    localparam int  CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  fq_entry_t     wdata,
    output fq_entry_t     rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    assign rdata = mem[rp];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clear) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wp] <= wdata;
    end

    // The credit scheme upstream must never let a push land on a full queue
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && !clear && full && !pop)
    );

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage with IF/ID register over a variable-latency imem port.
// Define IFETCH_PERF_EN to add FetchCount/BubbleCount performance counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QLIM = QDEPTH[CW:0];

    logic [31:0]   pcf;
    logic [31:0]   rsp_pc;
    logic [31:0]   tgt;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] qcount;
    logic [CW:0]   credit;
    logic          qfull;
    logic          qempty;
    logic          accept;
    logic          keep;
    logic          update;
    logic          bubble;
    logic          pop;
    fq_entry_t     head;
    fq_entry_t     wentry;
    logic          unused_bits;

    assign tgt         = {PCTargetE[31:2], 2'b00};
    assign unused_bits = ^{PCTargetE[1:0], qfull};

    // Words in flight plus words queued may never exceed the queue depth
    assign credit       = {1'b0, inflight} + {1'b0, qcount};
    assign ImemReqValid = rst_n && !PCSrcE && (credit < QLIM);
    assign ImemAddr     = pcf;
    assign accept       = ImemReqValid && ImemReqReady;

    assign keep   = ImemRspValid && !PCSrcE && (drop == '0);
    assign wentry = '{pc: rsp_pc, instr: ImemRspData};

    assign update = !StallD || FlushD || PCSrcE;
    assign bubble = FlushD || PCSrcE || qempty;
    assign pop    = update && !bubble;

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (PCSrcE),
        .push  (keep),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .full  (qfull),
        .empty (qempty),
        .count (qcount)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf      <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(ImemRspValid);
            if (PCSrcE) begin
                // Everything still outstanding belongs to the old path
                pcf    <= tgt;
                rsp_pc <= tgt;
                drop   <= inflight - CW'(ImemRspValid);
            end else begin
                if (accept) pcf <= pcf + 32'd4;
                if (keep) rsp_pc <= rsp_pc + 32'd4;
                if (ImemRspValid && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (update) begin
            if (bubble) begin
                InstrD   <= NOP;
                PCD      <= '0;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end else begin
                InstrD   <= head.instr;
                PCD      <= head.pc;
                PCPlus4D <= head.pc + 32'd4;
                ValidD   <= 1'b1;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FetchCount  <= '0;
            BubbleCount <= '0;
        end else begin
            if (pop) FetchCount <= FetchCount + 32'd1;
            if (!StallD && !pop) BubbleCount <= BubbleCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with an epoch-based program-order model
// and an in-order variable-latency imem model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        ImemReqValid;
    logic        ImemReqReady = 1'b0;
    logic [31:0] ImemAddr;
    logic        ImemRspValid = 1'b0;
    logic [31:0] ImemRspData = '0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef IFETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] BubbleCount;
`endif

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCSrcE       (PCSrcE),
        .PCTargetE    (PCTargetE),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemAddr     (ImemAddr),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD)
`ifdef IFETCH_PERF_EN
        ,
        .FetchCount   (FetchCount),
        .BubbleCount  (BubbleCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] bq[$];
    int          epoch;
    int          cyc;
    logic [31:0] req_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    int          fetch_m;
    int          bubble_m;
    int          delivered;

    int          lat = 1;
    int          p_ready = 100;
    int          p_rsp = 100;
    int          p_stall = 0;
    int          p_flush = 0;
    int          p_redir = 0;
    bit          f_stall, f_flush, f_redir;
    logic [31:0] f_tgt;

    int nchk = 0;
    int nerr = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", n, a, e, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        bq.delete();
        epoch    = 0;
        cyc      = 0;
        req_pc   = 32'h0;
        e_valid  = 1'b0;
        e_instr  = NOP;
        e_pc     = '0;
        e_pc4    = '0;
        fetch_m  = 0;
        bubble_m = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        PCSrcE       = 1'b0;
        StallD       = 1'b0;
        FlushD       = 1'b0;
        ImemReqReady = 1'b0;
        ImemRspValid = 1'b0;
        #1;
        chk("rst_valid", ValidD, 0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd", PCD, 0);
        chk("rst_pc4", PCPlus4D, 0);
        chk("rst_reqvalid", ImemReqValid, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic step();
        bit   rv;
        bit   upd;
        req_t r;
        logic [31:0] w;
        @(negedge clk);
        chk("ValidD", ValidD, e_valid);
        chk("InstrD", InstrD, e_instr);
        if (e_valid) begin
            chk("PCD", PCD, e_pc);
            chk("PCPlus4D", PCPlus4D, e_pc4);
        end
`ifdef IFETCH_PERF_EN
        chk("FetchCount", FetchCount, fetch_m);
        chk("BubbleCount", BubbleCount, bubble_m);
`endif
        StallD = f_stall || pct(p_stall);
        FlushD = f_flush || pct(p_flush);
        PCSrcE = f_redir || pct(p_redir);
        if (f_redir)
            PCTargetE = f_tgt;
        else if (pct(20))
            PCTargetE = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        else
            PCTargetE = $urandom;
        ImemReqReady = pct(p_ready);
        ImemRspValid = (pend.size() > 0) && (pend[0].due <= cyc) && pct(p_rsp);
        ImemRspData  = ImemRspValid ? memword(pend[0].addr) : $urandom;
        #1;
        rv = !PCSrcE && (pend.size() + bq.size() < QD);
        chk("ReqValid", ImemReqValid, rv);
        if (rv) chk("ImemAddr", ImemAddr, req_pc);
        upd = !StallD || FlushD || PCSrcE;
        if (upd) begin
            if (FlushD || PCSrcE || bq.size() == 0) begin
                e_valid = 1'b0;
                e_instr = NOP;
                if (!StallD) bubble_m++;
            end else begin
                w = bq.pop_front();
                e_valid = 1'b1;
                e_instr = memword(w);
                e_pc    = w;
                e_pc4   = w + 32'd4;
                fetch_m++;
                delivered++;
            end
        end
        if (ImemRspValid) begin
            r = pend.pop_front();
            if (r.ep == epoch && !PCSrcE) bq.push_back(r.addr);
        end
        if (rv && ImemReqReady) begin
            pend.push_back(req_t'{addr: req_pc, ep: epoch, due: cyc + lat});
            req_pc = req_pc + 32'd4;
        end
        if (PCSrcE) begin
            epoch++;
            bq.delete();
            req_pc = PCTargetE & ~32'd3;
        end
        cyc++;
        f_stall = 1'b0;
        f_flush = 1'b0;
        f_redir = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        delivered = 0;
        f_stall = 0;
        f_flush = 0;
        f_redir = 0;
        f_tgt = '0;

        // Straight-line fetch with a 1-cycle imem
        lat = 1;
        do_reset();
        repeat (4) step();
        chk("t1_e2_valid", ValidD, 1);
        chk("t1_e2_pc", PCD, 32'h0);
        chk("t1_e2_instr", InstrD, 32'h1357_9BDF);
        step();
        chk("t1_e3_pc", PCD, 32'h4);
        step();
        chk("t1_e4_bubble", ValidD, 0);
        step();
        chk("t1_e5_pc", PCD, 32'h8);
        chk("t1_e5_pc4", PCPlus4D, 32'hC);

        // Memory not ready: address held, no duplicate fetch
        do_reset();
        repeat (2) step();
        p_ready = 0;
        repeat (3) step();
        chk("t2_addr_hold", ImemAddr, 32'h8);
        chk("t2_req_hold", ImemReqValid, 1);
        repeat (3) step();
        chk("t2_bubble", ValidD, 0);
        p_ready = 100;
        repeat (8) step();

        // Stall with a full queue: no credit, nothing lost
        p_stall = 100;
        repeat (5) step();
        chk("t3_no_credit", ImemReqValid, 0);
        p_stall = 0;
        repeat (8) step();

        // Redirect with two words in flight on a 3-cycle imem
        lat = 3;
        do_reset();
        repeat (2) step();
        f_redir = 1;
        f_tgt = 32'h0000_0103;
        step();
        step();
        chk("t4_addr", ImemAddr, 32'h100);
        for (int i = 0; i < 20 && ValidD !== 1'b1; i++) step();
        chk("t4_first_valid", ValidD, 1);
        chk("t4_first_pc", PCD, 32'h100);

        // Stall and flush together, then reset mid-fetch
        f_stall = 1;
        f_flush = 1;
        step();
        step();
        chk("t5_flush_valid", ValidD, 0);
        chk("t5_flush_instr", InstrD, NOP);
        step();
        do_reset();

        // Randomized phases
        for (int ph = 0; ph < 6; ph++) begin
            lat     = $urandom_range(1, 4);
            p_ready = $urandom_range(30, 100);
            p_rsp   = $urandom_range(50, 100);
            p_stall = 20;
            p_flush = 8;
            p_redir = 5;
            if (ph == 3) do_reset();
            repeat (400) step();
        end
        chk("liveness", delivered > 100, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
